i2s_rx_frame: RTL and testbench

//  Parametrised I2S/left-justified serial audio receiver; successor to the 8-bit i2s_to_pcm front end.
//  clk is the serial bit clock (SCK): sd and ws are sampled on every rising edge of clk.

---
 rtl/i2s_rx_frame.sv | 183 ++++++++++++++++++
 tb/tb_i2s_rx_frame.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_frame.sv
// i2s_rx_frame
//   Parametrised I2S / left-justified serial audio receiver. clk is the serial
//   bit clock; ws and sd are sampled on every rising edge. Left/right slots are
//   deframed and published as an aligned stereo pair with a one-cycle strobe.
//   Malformed slots are flagged with sticky error bits.
//
// Parameters
//   SAMPLE_BITS    captured PCM width (MSB first; extra slot bits ignored)
//   MAX_SLOT_BITS  longest legal slot; a longer slot raises long_err
//   MODE           0 = Philips I2S (MSB one clk after ws edge)
//                  1 = left-justified (MSB on the ws edge)
//
// Ports
//   clk        in   serial bit clock, all logic on posedge
//   reset      in   asynchronous, active-high
//   en         in   receive enable; low returns to HUNT, outputs hold
//   ws         in   word select; 0 = left slot, 1 = right slot
//   sd         in   serial data
//   left_pcm   out  last published left sample
//   right_pcm  out  last published right sample
//   pcm_valid  out  one-cycle pulse when left_pcm/right_pcm update
//   short_err  out  sticky: a tracked slot ended with fewer than SAMPLE_BITS bits
//   long_err   out  sticky: a tracked slot exceeded MAX_SLOT_BITS bits
module i2s_rx_frame #(
  parameter int SAMPLE_BITS   = 16,
  parameter int MAX_SLOT_BITS = 32,
  parameter int MODE          = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   ws,
  input  logic                   sd,
  output logic [SAMPLE_BITS-1:0] left_pcm,
  output logic [SAMPLE_BITS-1:0] right_pcm,
  output logic                   pcm_valid,
  output logic                   short_err,
  output logic                   long_err
);

  localparam int CW = $clog2(MAX_SLOT_BITS + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_SLOT_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_SLOT_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    HUNT,
    LEFT,
    RIGHT
  } state_t;

  state_t state, state_next;

  logic                   ws_d;
  logic                   eff_ws;
  logic                   eff_ws_prev;
  logic                   boundary;
  logic                   rise;
  logic                   fall;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [SAMPLE_BITS-1:0] shreg_next;
  logic [SAMPLE_BITS-1:0] left_hold;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic                   do_hold;
  logic                   do_publish;
  logic                   do_short;
  logic                   do_long;

  // In I2S mode ws leads the MSB by one clock; delaying it once lines the
  // detected boundary up with the MSB edge in both modes.
  assign eff_ws   = (MODE == 0) ? ws_d : ws;
  assign boundary = eff_ws != eff_ws_prev;
  assign rise     = boundary && eff_ws;
  assign fall     = boundary && !eff_ws;

  // Slot shifter: the boundary bit is the MSB of the new slot; later bits fill
  // downward until SAMPLE_BITS are held, anything beyond is dropped.
  always_comb begin
    shreg_next = shreg;
    cnt_next   = cnt;
    if (boundary) begin
      shreg_next                = '0;
      shreg_next[SAMPLE_BITS-1] = sd;
      cnt_next                  = CNT_ONE;
    end else begin
      for (int unsigned i = 0; i < SAMPLE_BITS; i++) begin
        if (cnt == CW'(SAMPLE_BITS - 1 - i)) begin
          shreg_next[i] = sd;
        end
      end
      if (cnt != CNT_SAT) begin
        cnt_next = cnt + CNT_ONE;
      end
    end
  end

  // Frame tracker. A boundary edge closes the slot in progress before the new
  // one starts, so a boundary with cnt == MAX_SLOT_BITS is a legal end; only a
  // non-boundary edge at that count overruns the slot.
  always_comb begin
    state_next = state;
    do_hold    = 1'b0;
    do_publish = 1'b0;
    do_short   = 1'b0;
    do_long    = 1'b0;
    if (!en) begin
      state_next = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (fall) begin
            state_next = LEFT;
          end
        end
        LEFT, RIGHT: begin
          if (boundary) begin
            if (cnt < CNT_FULL) begin
              do_short = 1'b1;
            end
            if (state == LEFT && rise) begin
              do_hold    = 1'b1;
              state_next = RIGHT;
            end else if (state == RIGHT && fall) begin
              do_publish = 1'b1;
              state_next = LEFT;
            end
          end else if (cnt == CNT_MAX) begin
            do_long    = 1'b1;
            state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_d        <= 1'b0;
      eff_ws_prev <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      left_hold   <= '0;
      left_pcm    <= '0;
      right_pcm   <= '0;
      pcm_valid   <= 1'b0;
      short_err   <= 1'b0;
      long_err    <= 1'b0;
    end else begin
      ws_d        <= ws;
      eff_ws_prev <= eff_ws;
      shreg       <= shreg_next;
      cnt         <= cnt_next;
      pcm_valid   <= do_publish;
      if (!en) begin
        left_hold <= '0;
      end else if (do_hold) begin
        left_hold <= shreg;
      end
      if (do_publish) begin
        left_pcm  <= left_hold;
        right_pcm <= shreg;
      end
      if (do_short) begin
        short_err <= 1'b1;
      end
      if (do_long) begin
        long_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_frame.sv
// Self-checking bench for i2s_rx_frame. One I2S-mode and one left-justified
// instance receive the same serial stream (ws advanced one clock for I2S), so
// both must publish identical results at identical clocks. Expected results
// come from a slot-level model computed over the whole stream before playback.
module tb_i2s_rx_frame;

  localparam int SB   = 8;
  localparam int MAXB = 16;
  localparam int NMAX = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          sd;
  logic          ws_i2s;
  logic          ws_lj;
  logic [SB-1:0] l0, r0, l1, r1;
  logic          v0, v1, se0, se1, le0, le1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_rx_frame #(.SAMPLE_BITS(SB), .MAX_SLOT_BITS(MAXB), .MODE(0)) dut_i2s (
    .clk(clk), .reset(reset), .en(en), .ws(ws_i2s), .sd(sd),
    .left_pcm(l0), .right_pcm(r0), .pcm_valid(v0),
    .short_err(se0), .long_err(le0)
  );

  i2s_rx_frame #(.SAMPLE_BITS(SB), .MAX_SLOT_BITS(MAXB), .MODE(1)) dut_lj (
    .clk(clk), .reset(reset), .en(en), .ws(ws_lj), .sd(sd),
    .left_pcm(l1), .right_pcm(r1), .pcm_valid(v1),
    .short_err(se1), .long_err(le1)
  );

  // Stream: per clock, the ws of the slot the bit belongs to, sd and en.
  bit q_ws[$];
  bit q_sd[$];
  bit q_en[$];

  // Model events, indexed by the clock whose rising edge causes them.
  bit            ev_pub[NMAX];
  logic [SB-1:0] ev_l[NMAX];
  logic [SB-1:0] ev_r[NMAX];
  bit            ev_short[NMAX];
  bit            ev_long[NMAX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stream();
    q_ws.delete();
    q_sd.delete();
    q_en.delete();
  endtask

  task automatic add_bits(input bit w, input int n, input logic [31:0] val, input bit e);
    for (int i = n - 1; i >= 0; i--) begin
      q_ws.push_back(w);
      q_sd.push_back(val[i]);
      q_en.push_back(e);
    end
  endtask

  // Slot-level reference: split the stream into ws runs, decide which slots
  // are tracked (synchronised), and record publish/error events.
  task automatic build_model();
    int            n;
    int            st[$];
    int            ln[$];
    bit            wv[$];
    logic [SB-1:0] dq[$];
    logic [SB-1:0] hold;
    logic [SB-1:0] d;
    bit            prev_trk;
    bit            trk;
    bit            off_found;
    int            first_off;
    n = q_ws.size();
    for (int t = 0; t < NMAX; t++) begin
      ev_pub[t] = 0; ev_short[t] = 0; ev_long[t] = 0;
      ev_l[t] = '0; ev_r[t] = '0;
    end
    st.push_back(0);
    wv.push_back(q_ws[0]);
    for (int t = 1; t < n; t++) begin
      if (q_ws[t] != q_ws[t-1]) begin
        st.push_back(t);
        wv.push_back(q_ws[t]);
      end
    end
    for (int k = 0; k < st.size(); k++) begin
      ln.push_back(((k + 1 < st.size()) ? st[k+1] : n) - st[k]);
      d = '0;
      for (int j = 0; j < ln[k] && j < SB; j++) d[SB-1-j] = q_sd[st[k] + j];
      dq.push_back(d);
    end
    prev_trk = 0;
    hold     = '0;
    for (int k = 0; k < st.size(); k++) begin
      if (k == 0 || !q_en[st[k]]) begin
        trk = 0;
      end else if (prev_trk) begin
        if (ln[k-1] < SB) ev_short[st[k]] = 1;
        if (wv[k-1] == 0) begin
          hold = dq[k-1];
        end else begin
          ev_pub[st[k]] = 1;
          ev_l[st[k]]   = hold;
          ev_r[st[k]]   = dq[k-1];
        end
        trk = 1;
      end else begin
        trk = (wv[k] == 0);
      end
      if (trk) begin
        off_found = 0;
        first_off = n;
        for (int t = st[k] + 1; t < st[k] + ln[k]; t++) begin
          if (!q_en[t] && !off_found) begin
            off_found = 1;
            first_off = t;
          end
        end
        if (ln[k] > MAXB && st[k] + MAXB < first_off) ev_long[st[k] + MAXB] = 1;
        if (ln[k] > MAXB || off_found) trk = 0;
      end
      prev_trk = trk;
    end
  endtask

  // Reset both DUTs, play the stream and compare every clock. With
  // async_rst_end set, reset is raised between edges after the last bit.
  task automatic run_stream(input bit async_rst_end);
    int            n;
    logic [SB-1:0] exp_l;
    logic [SB-1:0] exp_r;
    bit            exp_se;
    bit            exp_le;
    n = q_ws.size();
    build_model();
    @(negedge clk);
    reset = 1; en = 1; sd = 0; ws_i2s = 0; ws_lj = 0;
    @(negedge clk);
    check("rst_left_i2s", l0, 0);  check("rst_right_i2s", r0, 0);
    check("rst_valid_i2s", v0, 0); check("rst_err_i2s", {se0, le0}, 0);
    check("rst_left_lj", l1, 0);   check("rst_right_lj", r1, 0);
    check("rst_valid_lj", v1, 0);  check("rst_err_lj", {se1, le1}, 0);
    reset  = 0;
    exp_l  = '0; exp_r = '0; exp_se = 0; exp_le = 0;
    for (int t = 0; t < n; t++) begin
      sd     = q_sd[t];
      en     = q_en[t];
      ws_lj  = q_ws[t];
      ws_i2s = (t + 1 < n) ? q_ws[t+1] : q_ws[t];
      @(negedge clk);
      if (ev_pub[t]) begin
        exp_l = ev_l[t];
        exp_r = ev_r[t];
      end
      if (ev_short[t]) exp_se = 1;
      if (ev_long[t])  exp_le = 1;
      check("valid_i2s", v0, ev_pub[t]);  check("valid_lj", v1, ev_pub[t]);
      check("left_i2s", l0, exp_l);       check("left_lj", l1, exp_l);
      check("right_i2s", r0, exp_r);      check("right_lj", r1, exp_r);
      check("short_i2s", se0, exp_se);    check("short_lj", se1, exp_se);
      check("long_i2s", le0, exp_le);     check("long_lj", le1, exp_le);
    end
    if (async_rst_end) begin
      #2 reset = 1;
      #1;
      check("async_rst_i2s", {l0, r0, v0, se0, le0}, 0);
      check("async_rst_lj", {l1, r1, v1, se1, le1}, 0);
    end
  endtask

  task automatic rand_run();
    int len;
    int r;
    int off;
    int offn;
    bit w;
    clear_stream();
    add_bits(0, 2, 0, 1);
    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      len = $urandom_range(2, 7);
      else if (r < 25) len = $urandom_range(17, 21);
      else             len = $urandom_range(8, 16);
      w    = (k % 2 == 0);
      off  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : len;
      offn = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        q_ws.push_back(w);
        q_sd.push_back(1'($urandom_range(0, 1)));
        q_en.push_back(!(j >= off && j < off + offn));
      end
    end
    add_bits(0, 3, $urandom, 1);
    run_stream(0);
  endtask

  initial begin
    reset = 1; en = 0; sd = 0; ws_i2s = 0; ws_lj = 0;

    // 8-bit slots, first frame discarded while hunting
    clear_stream();
    add_bits(0, 2, 0, 1);
    for (int f = 0; f < 3; f++) begin
      add_bits(0, 8, 32'hA5, 1);
      add_bits(1, 8, 32'h3C, 1);
    end
    add_bits(0, 2, 32'h2, 1);
    run_stream(0);
    check("t1_left", l0, 8'hA5);
    check("t1_right", r1, 8'h3C);

    // 16-bit slots, trailing bits ignored, MAX-length slots are legal
    clear_stream();
    add_bits(0, 2, 0, 1);
    for (int f = 0; f < 3; f++) begin
      add_bits(0, 16, 32'h81FF, 1);
      add_bits(1, 16, 32'h7E00, 1);
    end
    add_bits(0, 2, 32'h3, 1);
    run_stream(0);
    check("t2_pair", {l0, r1}, 16'h817E);
    check("t2_errs", {se0, le0, se1, le1}, 0);

    // 6-bit slots: zero-padded, short_err, still published
    clear_stream();
    add_bits(0, 2, 0, 1);
    for (int f = 0; f < 3; f++) begin
      add_bits(0, 6, 32'h2D, 1);
      add_bits(1, 6, 32'h3F, 1);
    end
    add_bits(0, 2, 0, 1);
    run_stream(0);
    check("t3_pair", {l1, r0}, 16'hB4FC);
    check("t3_short", {se0, se1}, 2'b11);

    // Overlong left slot, then resync
    clear_stream();
    add_bits(0, 2, 0, 1);
    add_bits(0, 8, 32'h11, 1); add_bits(1, 8, 32'h22, 1);
    add_bits(0, 8, 32'h33, 1); add_bits(1, 8, 32'h44, 1);
    add_bits(0, 20, 32'hF0F0F, 1);
    add_bits(1, 8, 32'h55, 1);
    add_bits(0, 8, 32'h66, 1); add_bits(1, 8, 32'h77, 1);
    add_bits(0, 8, 32'h88, 1); add_bits(1, 8, 32'h99, 1);
    add_bits(0, 2, 0, 1);
    run_stream(0);
    check("t4_long", {le0, le1}, 2'b11);
    check("t4_pair", {l0, r0}, 16'h8899);

    // Async reset in the middle of a right slot
    clear_stream();
    add_bits(0, 2, 0, 1);
    add_bits(0, 8, 32'hA5, 1); add_bits(1, 8, 32'h3C, 1);
    add_bits(0, 8, 32'h5A, 1); add_bits(1, 8, 32'hC3, 1);
    add_bits(0, 8, 32'h11, 1); add_bits(1, 4, 32'h2, 1);
    run_stream(1);

    // en dropped for 5 clocks inside a left slot
    clear_stream();
    add_bits(0, 2, 0, 1);
    add_bits(0, 8, 32'h12, 1); add_bits(1, 8, 32'h34, 1);
    add_bits(0, 8, 32'h56, 1); add_bits(1, 8, 32'h78, 1);
    add_bits(0, 2, 32'h2, 1);  add_bits(0, 5, 32'h15, 0); add_bits(0, 1, 32'h1, 1);
    add_bits(1, 8, 32'h9A, 1);
    add_bits(0, 8, 32'hBC, 1); add_bits(1, 8, 32'hDE, 1);
    add_bits(0, 8, 32'hF1, 1); add_bits(1, 8, 32'h2E, 1);
    add_bits(0, 2, 0, 1);
    run_stream(0);
    check("t6_pair", {l1, r1}, 16'hF12E);

    for (int i = 0; i < 10; i++) rand_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
